// File: rtl/clkdiv_prog.sv
// Programmable multi-channel clock-enable generator.
// Each channel has a reloading down-counter, shadowed config registers and a pulse or square output.
module clkdiv_prog #(
  parameter int NCH     = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic             sync_i,
  input  logic             cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   cfg_pend,
  output logic [NCH-1:0]   tick_o,
  output logic [NCH-1:0]   wave_o
);

  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

  // Shared write decoder; selects at or beyond NCH match no channel and are dropped.
  logic [NCH-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_we && (32'(cfg_sel) == 32'(i))) begin
        wr_hit[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_sh;
    logic             mode_act;
    logic             mode_sh;
    logic             pend;
    logic             tick;
    logic             sq;
    logic             wave;
    logic [DIV_W-1:0] nxt_div;
    logic             nxt_mode;

    // Value that becomes active at the next commit point.
    always_comb begin
      nxt_div  = pend ? div_sh  : div_act;
      nxt_mode = pend ? mode_sh : mode_act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= DEF_VAL;
        div_act  <= DEF_VAL;
        div_sh   <= DEF_VAL;
        mode_act <= 1'b0;
        mode_sh  <= 1'b0;
        pend     <= 1'b0;
        tick     <= 1'b0;
        sq       <= 1'b0;
        wave     <= 1'b0;
      end else if (!ch_en[g] || sync_i) begin
        // Idle or phase-align: commit immediately, using a same-cycle write if present.
        if (wr_hit[g]) begin
          div_act  <= cfg_div;
          mode_act <= cfg_mode;
          div_sh   <= cfg_div;
          mode_sh  <= cfg_mode;
          cnt      <= cfg_div;
        end else begin
          div_act  <= nxt_div;
          mode_act <= nxt_mode;
          cnt      <= nxt_div;
        end
        pend <= 1'b0;
        tick <= 1'b0;
        sq   <= 1'b0;
        wave <= 1'b0;
      end else if (cnt != '0) begin
        cnt  <= cnt - DIV_W'(1);
        tick <= 1'b0;
        wave <= mode_act & sq;
        if (wr_hit[g]) begin
          div_sh  <= cfg_div;
          mode_sh <= cfg_mode;
          pend    <= 1'b1;
        end
      end else begin
        // Terminal count: reload from the committed value; a write landing now waits a period.
        tick     <= 1'b1;
        div_act  <= nxt_div;
        mode_act <= nxt_mode;
        cnt      <= nxt_div;
        sq       <= nxt_mode & ~sq;
        wave     <= nxt_mode ? ~sq : 1'b1;
        if (wr_hit[g]) begin
          div_sh  <= cfg_div;
          mode_sh <= cfg_mode;
          pend    <= 1'b1;
        end else begin
          pend <= 1'b0;
        end
      end
    end

    assign tick_o[g]   = tick;
    assign wave_o[g]   = wave;
    assign cfg_pend[g] = pend;
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Scoreboard bench for clkdiv_prog: directed stimulus queues expected per-channel outputs,
// a monitor compares them one cycle-tag at a time. A 3-channel instance covers out-of-range selects.
module tb_clkdiv_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic        sync_i;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [3:0]  t4, w4, p4;
  logic [2:0]  t3, w3, p3;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         at;
    bit         d3;
    int         ch;
    logic [2:0] req;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  clkdiv_prog #(.NCH(4), .DIV_W(16), .DEF_DIV(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .sync_i(sync_i), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .cfg_pend(p4), .tick_o(t4), .wave_o(w4)
  );

  clkdiv_prog #(.NCH(3), .DIV_W(16), .DEF_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en[2:0]), .sync_i(sync_i), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .cfg_pend(p3), .tick_o(t3), .wave_o(w3)
  );

  always #5 clk = ~clk;

  // cyc holds the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b required %b", tag, act, req);
    end
  endtask

  // Drive one set of inputs so that it is sampled at rising edge number 'at'.
  task automatic applyStimulus(input int at, input logic [3:0] en, input logic sy,
                               input logic we, input logic [1:0] sel,
                               input logic [15:0] dv, input logic md);
    @(negedge clk);
    while (cyc < at - 1) @(negedge clk);
    if (cyc != at - 1) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL schedule: at edge %0d required edge %0d", cyc + 1, at);
    end
    ch_en    = en;
    sync_i   = sy;
    cfg_we   = we;
    cfg_sel  = sel;
    cfg_div  = dv;
    cfg_mode = md;
  endtask

  // req = {tick, wave, pend} expected after edge 'at'.
  task automatic expectCh(input int at, input bit d3, input int ch, input logic [2:0] req,
                          input string tag);
    exp_t e;
    e.at = at; e.d3 = d3; e.ch = ch; e.req = req; e.tag = tag;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].at < cyc) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: entry for edge %0d missed, now %0d", sbq[k].tag, sbq[k].at, cyc);
        sbq.delete(k);
      end else if (sbq[k].at == cyc) begin
        if (sbq[k].d3)
          checkOutput($sformatf("%s dut3 ch%0d @%0d", sbq[k].tag, sbq[k].ch, cyc),
                      {13'b0, t3[sbq[k].ch], w3[sbq[k].ch], p3[sbq[k].ch]}, {13'b0, sbq[k].req});
        else
          checkOutput($sformatf("%s ch%0d @%0d", sbq[k].tag, sbq[k].ch, cyc),
                      {13'b0, t4[sbq[k].ch], w4[sbq[k].ch], p4[sbq[k].ch]}, {13'b0, sbq[k].req});
        sbq.delete(k);
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not complete, edge %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e1, w, f, s, y, b, z, r;
    rst_n = 1'b0; ch_en = '0; sync_i = 0; cfg_we = 0; cfg_sel = '0; cfg_div = '0; cfg_mode = 0;
    for (int c = 0; c < 4; c++) begin
      expectCh(1, 0, c, 3'b000, "reset");
      expectCh(2, 0, c, 3'b000, "reset");
    end
    expectCh(2, 1, 0, 3'b000, "reset");
    while (cyc < 2) @(negedge clk);
    rst_n = 1'b1;

    // Default clk/4 on channel 0
    e1 = 4;
    applyStimulus(e1, 4'b0001, 0, 0, 2'd0, 16'd0, 0);
    expectCh(e1 + 2,  0, 0, 3'b000, "def");
    expectCh(e1 + 3,  0, 0, 3'b110, "def");
    expectCh(e1 + 4,  0, 0, 3'b000, "def");
    expectCh(e1 + 6,  0, 0, 3'b000, "def");
    expectCh(e1 + 7,  0, 0, 3'b110, "def");
    expectCh(e1 + 11, 0, 0, 3'b110, "def");
    expectCh(e1 + 3,  0, 1, 3'b000, "def_other");
    expectCh(e1 + 7,  0, 2, 3'b000, "def_other");
    expectCh(e1 + 11, 0, 3, 3'b000, "def_other");
    expectCh(e1 + 3,  1, 0, 3'b110, "def");

    // Idle write of square mode div 9 to channel 1, then enable
    w = e1 + 12;
    f = w + 1;
    applyStimulus(w, 4'b0001, 0, 1, 2'd1, 16'd9, 1);
    expectCh(w, 0, 1, 3'b000, "idle_wr");
    applyStimulus(f, 4'b0011, 0, 0, 2'd0, 16'd0, 0);
    expectCh(f + 8,  0, 1, 3'b000, "square");
    expectCh(f + 9,  0, 1, 3'b110, "square");
    expectCh(f + 10, 0, 1, 3'b010, "square");
    expectCh(f + 18, 0, 1, 3'b010, "square");
    expectCh(f + 19, 0, 1, 3'b100, "square");
    expectCh(f + 28, 0, 1, 3'b000, "square");
    expectCh(f + 29, 0, 1, 3'b110, "square");

    // Mid-period rewrite of channel 0 stays pending until the next tick
    s = f + 30;
    applyStimulus(s, 4'b0011, 1, 0, 2'd0, 16'd0, 0);
    expectCh(s,      0, 0, 3'b000, "pend");
    expectCh(s + 3,  0, 0, 3'b000, "pend");
    expectCh(s + 4,  0, 0, 3'b110, "pend");
    expectCh(s + 5,  0, 0, 3'b001, "pend");
    expectCh(s + 7,  0, 0, 3'b001, "pend");
    expectCh(s + 8,  0, 0, 3'b110, "pend");
    expectCh(s + 12, 0, 0, 3'b000, "pend");
    expectCh(s + 15, 0, 0, 3'b000, "pend");
    expectCh(s + 16, 0, 0, 3'b110, "pend");
    expectCh(s + 24, 0, 0, 3'b110, "pend");
    applyStimulus(s + 1, 4'b0011, 0, 0, 2'd0, 16'd0, 0);
    applyStimulus(s + 5, 4'b0011, 0, 1, 2'd0, 16'd7, 0);
    applyStimulus(s + 6, 4'b0011, 0, 0, 2'd0, 16'd0, 0);

    // Sync alignment, write at terminal count, back-to-back writes
    y = s + 26;
    applyStimulus(y - 1, 4'b0011, 0, 1, 2'd2, 16'd5, 0);
    expectCh(y - 1, 0, 2, 3'b000, "sync");
    applyStimulus(y, 4'b0111, 1, 1, 2'd0, 16'd2, 0);
    expectCh(y,      0, 0, 3'b000, "sync");
    expectCh(y + 3,  0, 0, 3'b110, "sync");
    expectCh(y + 4,  0, 0, 3'b000, "sync");
    expectCh(y + 5,  0, 2, 3'b000, "sync");
    expectCh(y + 6,  0, 0, 3'b110, "sync");
    expectCh(y + 6,  0, 2, 3'b110, "sync");
    expectCh(y + 9,  0, 0, 3'b110, "sync");
    expectCh(y + 9,  0, 2, 3'b000, "sync");
    expectCh(y + 12, 0, 0, 3'b111, "tc_wr");
    expectCh(y + 12, 0, 2, 3'b110, "sync");
    expectCh(y + 13, 0, 0, 3'b001, "tc_wr");
    expectCh(y + 15, 0, 0, 3'b110, "tc_wr");
    expectCh(y + 16, 0, 0, 3'b001, "last_wr");
    expectCh(y + 17, 0, 0, 3'b001, "last_wr");
    expectCh(y + 18, 0, 0, 3'b001, "last_wr");
    expectCh(y + 19, 0, 0, 3'b001, "last_wr");
    expectCh(y + 20, 0, 0, 3'b110, "last_wr");
    expectCh(y + 21, 0, 0, 3'b000, "last_wr");
    expectCh(y + 22, 0, 0, 3'b110, "last_wr");
    expectCh(y + 23, 0, 0, 3'b000, "last_wr");
    expectCh(y + 24, 0, 0, 3'b110, "last_wr");
    applyStimulus(y + 1,  4'b0111, 0, 0, 2'd0, 16'd0, 0);
    applyStimulus(y + 12, 4'b0111, 0, 1, 2'd0, 16'd4, 0);
    applyStimulus(y + 13, 4'b0111, 0, 0, 2'd0, 16'd0, 0);
    applyStimulus(y + 16, 4'b0111, 0, 1, 2'd0, 16'd6, 0);
    applyStimulus(y + 17, 4'b0111, 0, 1, 2'd0, 16'd1, 0);
    applyStimulus(y + 18, 4'b0111, 0, 0, 2'd0, 16'd0, 0);

    // Div 0 on channel 3; select 3 is out of range for the 3-channel instance
    b = y + 26;
    applyStimulus(b, 4'b0111, 0, 1, 2'd3, 16'd0, 0);
    expectCh(b,     0, 3, 3'b000, "div0");
    expectCh(b,     1, 0, 3'b110, "oor");
    expectCh(b,     1, 1, 3'b000, "oor");
    expectCh(b,     1, 2, 3'b000, "oor");
    expectCh(b + 1, 0, 3, 3'b000, "div0");
    expectCh(b + 2, 0, 3, 3'b110, "div0");
    expectCh(b + 4, 0, 3, 3'b110, "div0");
    expectCh(b + 6, 0, 3, 3'b110, "div0");
    expectCh(b + 1, 1, 0, 3'b000, "oor");
    expectCh(b + 3, 1, 0, 3'b110, "oor");
    expectCh(b + 4, 1, 0, 3'b000, "oor");
    expectCh(b + 5, 1, 0, 3'b110, "oor");
    expectCh(b + 6, 1, 2, 3'b000, "oor");
    expectCh(b + 7, 1, 2, 3'b110, "oor");
    applyStimulus(b + 1, 4'b1111, 1, 0, 2'd0, 16'd0, 0);
    applyStimulus(b + 2, 4'b1111, 0, 0, 2'd0, 16'd0, 0);

    // Asynchronous reset while channel 1 square output is high
    z = b + 8;
    applyStimulus(z, 4'b0010, 1, 0, 2'd0, 16'd0, 0);
    expectCh(z + 9,  0, 1, 3'b000, "pre_rst");
    expectCh(z + 10, 0, 1, 3'b110, "pre_rst");
    expectCh(z + 12, 0, 1, 3'b010, "pre_rst");
    for (int c = 0; c < 4; c++) begin
      expectCh(z + 13, 0, c, 3'b000, "in_rst");
      expectCh(z + 14, 0, c, 3'b000, "in_rst");
    end
    applyStimulus(z + 1, 4'b0010, 0, 0, 2'd0, 16'd0, 0);
    while (cyc < z + 12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst dut", {4'b0, t4, w4, p4}, 16'h0000);
    checkOutput("async_rst dut3", {7'b0, t3, w3, p3}, 16'h0000);
    while (cyc < z + 14) @(negedge clk);
    rst_n = 1'b1;

    r = z + 16;
    applyStimulus(r, 4'b0001, 0, 0, 2'd0, 16'd0, 0);
    expectCh(r + 2, 0, 0, 3'b000, "post_rst");
    expectCh(r + 3, 0, 0, 3'b110, "post_rst");
    expectCh(r + 6, 0, 0, 3'b000, "post_rst");
    expectCh(r + 7, 0, 0, 3'b110, "post_rst");
    expectCh(r + 3, 0, 1, 3'b000, "post_rst");

    while (cyc < r + 10) @(negedge clk);
    foreach (sbq[k]) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s: entry for edge %0d never checked", sbq[k].tag, sbq[k].at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
- Parametrised, run-time programmable enable/tick generator.
- Replaces fixed power-of-4 clock-enable dividers with NCH independent channels.
- Each channel has its own divide ratio, output mode and enable, plus a global phase-align input.
- Sits beside the core clock and feeds clock-enable strobes to the sigma-delta and peripheral logic; all logic stays on the single clk.

Parameters:
NCH, 4, number of independent divider channels (1..16)
DIV_W, 16, width of divide value and channel down-counter
DEF_DIV, 3, divide value loaded at reset (period DEF_DIV+1 = clk/4)
SEL_W, derived = max(1, clog2(NCH)), width of channel select (localparam)

Ports:
clk  input  1  system clock, all logic posedge
rst_n  input  1  asynchronous active-low reset
ch_en  input  NCH  per-channel run enable
sync_i  input  1  global phase align, one-cycle pulse
cfg_we  input  1  config write strobe
cfg_sel  input  SEL_W  target channel of config write
cfg_div  input  DIV_W  new divide value (period = cfg_div+1)
cfg_mode  input  1  0 = pulse mode, 1 = square mode
cfg_pend  output  NCH  shadow config written but not yet active
tick_o  output  NCH  one-cycle enable strobe per channel
wave_o  output  NCH  pulse mode: equals tick_o; square mode: 50% square wave

Behaviour:
- Per channel state: cnt[DIV_W], div_act, mode_act, div_sh, mode_sh, pend, tick, sq. All outputs are registered.
- Async reset (rst_n low): div_act = div_sh = DEF_DIV, cnt = DEF_DIV, mode_act = mode_sh = 0, pend = 0, tick_o = 0, wave_o = 0, sq = 0. Reset is immediate and independent of clk.
- Priority per edge, per channel: reset > ch_en low > sync_i > count.
- ch_en[i] low (idle):
  - Any pending shadow is committed (div_act/mode_act <= shadow, pend cleared).
  - cnt <= committed div.
  - tick = 0, sq = 0.
- sync_i high with ch_en[i] high:
  - Same commit and cnt reload as idle.
  - tick = 0, sq = 0.
  - All enabled channels therefore restart phase-aligned.
- Counting (ch_en[i] high, sync_i low):
  - cnt != 0: cnt <= cnt-1, tick <= 0.
  - cnt == 0 (terminal count): tick <= 1; if pend, commit shadow and clear pend; cnt <= div_act (the newly committed value if pend); if mode_act = 1 (post-commit), sq <= ~sq.
- Timing from an edge E0 that loads cnt = D with channel running: first tick_o high in the cycle after edge E0+D+1. Pulses then repeat every D+1 cycles.
- D = 0: tick_o held high continuously (every cycle).
- Square mode: wave_o = sq, period 2*(D+1), duty exactly 50%, toggling coincident with tick.
- Mode change from square to pulse at commit: sq cleared at that commit.
- Config write (cfg_we high, cfg_sel < NCH):
  - div_sh/mode_sh <= cfg_div/cfg_mode, pend <= 1, unless the channel is idle that cycle (then committed directly, pend stays 0).
  - cfg_sel >= NCH: write ignored, no state change.
- Write while pend set: shadow overwritten, only the last value commits.
- Write in the same cycle as terminal count on the same channel:
  - Reload uses the previously committed/pending value.
  - The new write remains pending (pend = 1) until the next terminal count.
- Write in the same cycle as sync_i: the new value commits immediately (sync commit uses incoming data).
- Counter never wraps: the down-counter always reloads at 0. The full DIV_W range is valid (max period 2^DIV_W).
- Target implementation: a generate loop over channels plus a shared write decoder.

Test Plan:
- Reset, ch_en = 4'b0001, no writes -> tick_o[0] pulses every 4 cycles, first pulse 4 cycles after enable; wave_o[0] == tick_o[0]; others stay 0.
- Write ch1 div = 9, mode = 1 while idle, then enable -> wave_o[1] high 10 cycles / low 10 cycles; tick_o[1] every 10 cycles; cfg_pend[1] never set.
- Ch0 running at div = 3, write div = 7 mid-period -> cfg_pend[0] = 1 until the next tick; that period is still 4 cycles, subsequent periods 8; pend clears with the tick.
- Ch0 div = 2, ch2 div = 5, pulse sync_i -> both counters reload, first ticks 3 and 6 cycles later; ch0 ticks coincide with ch2 every 6 cycles.
- Write div = 0 to ch3 and enable -> tick_o[3] constant 1. Write with cfg_sel beyond range (NCH = 3 build, sel = 3) -> no state change.
- Assert rst_n low asynchronously mid-count with square high -> all outputs 0 immediately, cnt/div back to DEF_DIV; after release, clk/4 operation resumes.
